// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU issue/writeback controller.
package alu_pkg;

  localparam int DW   = 8;
  localparam int NREG = 8;

  typedef enum logic [2:0] {
    OP_ZTST = 3'b010,
    OP_XOR  = 3'b011,
    OP_ROT  = 3'b100,
    OP_AND  = 3'b101,
    OP_ADD  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {OP_ZTST, OP_XOR, OP_ROT, OP_AND, OP_ADD};
  endfunction

  function automatic logic writes_back(input logic [2:0] op);
    return op inside {OP_XOR, OP_ROT, OP_AND, OP_ADD};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two operand read ports, one debug read port,
// one synchronous write port, asynchronously cleared.
module alu_regfile #(
  parameter int NREG = alu_pkg::NREG,
  parameter int DW   = alu_pkg::DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [DW-1:0]           wdata,
  input  logic [$clog2(NREG)-1:0] ra_addr,
  output logic [DW-1:0]           ra_data,
  input  logic [$clog2(NREG)-1:0] rb_addr,
  output logic [DW-1:0]           rb_data,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational ALU: latches one decoded
// instruction, reads operands, drives the ALU, writes back and updates flags.
module alu_issue_ctrl #(
  parameter int NREG = alu_pkg::NREG,
  parameter int DW   = alu_pkg::DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [2:0]              instr_op,
  input  logic [$clog2(NREG)-1:0] instr_rd,
  input  logic [$clog2(NREG)-1:0] instr_rs,
  input  logic                    instr_imm_en,
  input  logic [DW-1:0]           instr_imm,
  output logic [2:0]              alu_cmd,
  output logic [DW-1:0]           alu_ina,
  output logic [DW-1:0]           alu_inb,
  output logic                    alu_sc_i,
  input  logic [DW-1:0]           alu_rslt,
  input  logic                    alu_sc_o,
  output logic                    wb_valid,
  output logic [$clog2(NREG)-1:0] wb_rd,
  output logic [DW-1:0]           wb_data,
  output logic                    flag_c,
  output logic                    flag_z,
  output logic                    flag_p,
  output logic                    branch_taken,
  output logic                    illegal_op,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
);
  import alu_pkg::*;

  localparam int ADDR_W = $clog2(NREG);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d, rs_q, rs_d;
  logic                imm_en_q, imm_en_d;
  logic [DW-1:0]       imm_q, imm_d;
  logic [2:0]          alu_cmd_q, alu_cmd_d;
  logic [DW-1:0]       alu_ina_q, alu_ina_d, alu_inb_q, alu_inb_d;
  logic                alu_sc_i_q, alu_sc_i_d;
  logic                wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DW-1:0]       wb_data_q, wb_data_d;
  logic                flag_c_q, flag_c_d, flag_z_q, flag_z_d, flag_p_q, flag_p_d;
  logic                branch_taken_q, branch_taken_d;
  logic                illegal_op_q, illegal_op_d;
  logic [DW-1:0]       ra_data, rb_data, opb;

  // The register file commits the cycle after the WB pulse, from the held wb_* values.
  alu_regfile #(.NREG(NREG), .DW(DW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_valid_q),
    .waddr    (wb_rd_q),
    .wdata    (wb_data_q),
    .ra_addr  (rd_q),
    .ra_data  (ra_data),
    .rb_addr  (rs_q),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign opb = imm_en_q ? imm_q : rb_data;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rd_d           = rd_q;
    rs_d           = rs_q;
    imm_en_d       = imm_en_q;
    imm_d          = imm_q;
    alu_cmd_d      = '0;
    alu_ina_d      = '0;
    alu_inb_d      = '0;
    alu_sc_i_d     = 1'b0;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    flag_c_d       = flag_c_q;
    flag_z_d       = flag_z_q;
    flag_p_d       = flag_p_q;
    branch_taken_d = 1'b0;
    illegal_op_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d         = instr_op;
          rd_d         = instr_rd;
          rs_d         = instr_rs;
          imm_en_d     = instr_imm_en;
          imm_d        = instr_imm;
          illegal_op_d = !is_legal_op(instr_op);
          state_d      = READ;
        end
      end
      READ: begin
        if (!is_legal_op(op_q)) begin
          state_d = IDLE;
        end else begin
          state_d    = EXEC;
          alu_cmd_d  = op_q;
          alu_ina_d  = ra_data;
          // Rotate amount is only the low three bits of operand B.
          alu_inb_d  = (op_q == OP_ROT) ? (opb & DW'(3'b111)) : opb;
          alu_sc_i_d = flag_c_q;
        end
      end
      EXEC: begin
        state_d = WB;
        if (writes_back(op_q)) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = alu_rslt;
          flag_z_d   = (alu_rslt == '0);
          flag_p_d   = ^alu_rslt;
          if (op_q == OP_ADD) flag_c_d = alu_sc_o;
        end else begin
          branch_taken_d = (alu_ina_q == '0);
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_q           <= '0;
      rd_q           <= '0;
      rs_q           <= '0;
      imm_en_q       <= 1'b0;
      imm_q          <= '0;
      alu_cmd_q      <= '0;
      alu_ina_q      <= '0;
      alu_inb_q      <= '0;
      alu_sc_i_q     <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      flag_c_q       <= 1'b0;
      flag_z_q       <= 1'b0;
      flag_p_q       <= 1'b0;
      branch_taken_q <= 1'b0;
      illegal_op_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      rs_q           <= rs_d;
      imm_en_q       <= imm_en_d;
      imm_q          <= imm_d;
      alu_cmd_q      <= alu_cmd_d;
      alu_ina_q      <= alu_ina_d;
      alu_inb_q      <= alu_inb_d;
      alu_sc_i_q     <= alu_sc_i_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      flag_c_q       <= flag_c_d;
      flag_z_q       <= flag_z_d;
      flag_p_q       <= flag_p_d;
      branch_taken_q <= branch_taken_d;
      illegal_op_q   <= illegal_op_d;
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign alu_cmd      = alu_cmd_q;
  assign alu_ina      = alu_ina_q;
  assign alu_inb      = alu_inb_q;
  assign alu_sc_i     = alu_sc_i_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign flag_c       = flag_c_q;
  assign flag_z       = flag_z_q;
  assign flag_p       = flag_p_q;
  assign branch_taken = branch_taken_q;
  assign illegal_op   = illegal_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'b000, instr_rd = 3'b000, instr_rs = 3'b000;
  logic       instr_imm_en = 1'b0;
  logic [7:0] instr_imm = 8'h00;
  logic [2:0] alu_cmd;
  logic [7:0] alu_ina, alu_inb, alu_rslt;
  logic       alu_sc_i, alu_sc_o;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_c, flag_z, flag_p, branch_taken, illegal_op;
  logic [2:0] dbg_addr = 3'b000;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .alu_cmd(alu_cmd), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_sc_i(alu_sc_i),
    .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .flag_p(flag_p),
    .branch_taken(branch_taken), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU. Non-ADD ops return an inverted carry so a controller that
  // wrongly takes sc_o for XOR/ROT/AND visibly corrupts flag_c.
  function automatic logic [8:0] alu_fn(input logic [2:0] cmd, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    logic [7:0] r;
    case (cmd)
      3'b011:  alu_fn = {~cin, a ^ b};
      3'b101:  alu_fn = {~cin, a & b};
      3'b100: begin
        r = a;
        for (int i = 0; i < int'(b[2:0]); i++) r = {r[6:0], r[7]};
        alu_fn = {~cin, r};
      end
      3'b111:  alu_fn = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      default: alu_fn = 9'h000;
    endcase
  endfunction

  assign {alu_sc_o, alu_rslt} = alu_fn(alu_cmd, alu_ina, alu_inb, alu_sc_i);

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [7:0] a, b, data;
    logic       sc_i, illegal, wb, br, c, z, p;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_reg [8];
  logic       ref_c, ref_z, ref_p;
  int         n_assert = 0;
  int         n_fail = 0;
  logic       hold_next = 1'b0;
  logic [2:0] nxt_op = 3'b000, nxt_rd = 3'b000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (instr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 16'(instr_ready), 16'h1);
  endtask

  task automatic check_regs_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, 16'(dbg_data), 16'h00);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic ie, input logic [7:0] imm);
    exp_t e;
    logic [8:0] r;
    e.op      = op;
    e.rd      = rd;
    e.a       = ref_reg[rd];
    e.b       = ie ? imm : ref_reg[rs];
    if (op == 3'b100) e.b = e.b & 8'h07;
    e.sc_i    = ref_c;
    e.illegal = !(op inside {3'b010, 3'b011, 3'b100, 3'b101, 3'b111});
    e.wb      = op inside {3'b011, 3'b100, 3'b101, 3'b111};
    e.br      = (op == 3'b010) && (e.a == 8'h00);
    r         = alu_fn(op, e.a, e.b, ref_c);
    e.data    = r[7:0];
    if (e.wb) begin
      ref_reg[rd] = r[7:0];
      ref_z       = (r[7:0] == 8'h00);
      ref_p       = ^r[7:0];
      if (op == 3'b111) ref_c = r[8];
    end
    e.c = ref_c;
    e.z = ref_z;
    e.p = ref_p;
    sb.push_back(e);

    wait_ready();
    instr_valid  = 1'b1;
    instr_op     = op;
    instr_rd     = rd;
    instr_rs     = rs;
    instr_imm_en = ie;
    instr_imm    = imm;
    @(posedge clk);
    @(negedge clk);
    if (hold_next) begin
      instr_op = nxt_op;
      instr_rd = nxt_rd;
    end else begin
      instr_valid = 1'b0;
    end
    chk("busy_c1", 16'(instr_ready), 16'h0);
    if (sb[0].illegal) begin
      e = sb.pop_front();
      chk("illegal_pulse", 16'(illegal_op), 16'h1);
      @(negedge clk);
      chk("illegal_ready_c2", 16'(instr_ready), 16'h1);
      chk("illegal_pulse_end", 16'(illegal_op), 16'h0);
      chk("illegal_no_alu", 16'(alu_cmd), 16'h0);
      chk("illegal_flags", 16'({flag_c, flag_z, flag_p}), 16'({e.c, e.z, e.p}));
      @(negedge clk);
      chk("illegal_no_wb", 16'(wb_valid), 16'h0);
      dbg_addr = e.rd;
      #1;
      chk("illegal_reg_kept", 16'(dbg_data), 16'(ref_reg[e.rd]));
    end else begin
      chk("no_illegal", 16'(illegal_op), 16'h0);
      chk("no_early_wb_c1", 16'(wb_valid), 16'h0);
      @(negedge clk);
      chk("exec_cmd", 16'(alu_cmd), 16'(sb[0].op));
      chk("exec_ina", 16'(alu_ina), 16'(sb[0].a));
      chk("exec_inb", 16'(alu_inb), 16'(sb[0].b));
      chk("exec_sc_i", 16'(alu_sc_i), 16'(sb[0].sc_i));
      chk("busy_c2", 16'(instr_ready), 16'h0);
      chk("no_early_wb_c2", 16'(wb_valid), 16'h0);
      @(negedge clk);
      e = sb.pop_front();
      chk("wb_valid_c3", 16'(wb_valid), 16'(e.wb));
      if (e.wb) begin
        chk("wb_rd", 16'(wb_rd), 16'(e.rd));
        chk("wb_data", 16'(wb_data), 16'(e.data));
      end
      chk("branch_taken", 16'(branch_taken), 16'(e.br));
      chk("flags_czp", 16'({flag_c, flag_z, flag_p}), 16'({e.c, e.z, e.p}));
      chk("alu_idle_c3", 16'(alu_cmd), 16'h0);
      chk("busy_c3", 16'(instr_ready), 16'h0);
      @(negedge clk);
      chk("wb_pulse_end", 16'(wb_valid), 16'h0);
      chk("branch_pulse_end", 16'(branch_taken), 16'h0);
      chk("ready_c4", 16'(instr_ready), 16'h1);
      if (e.wb) chk("wb_data_hold", 16'(wb_data), 16'(e.data));
      dbg_addr = e.rd;
      #1;
      chk("dbg_after_wb", 16'(dbg_data), 16'(ref_reg[e.rd]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_reg[i] = 8'h00;
    ref_c = 1'b0; ref_z = 1'b0; ref_p = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 16'(instr_ready), 16'h1);
    chk("rst_flags", 16'({flag_c, flag_z, flag_p}), 16'h0);
    chk("rst_pulses", 16'({wb_valid, branch_taken, illegal_op}), 16'h0);
    chk("rst_alu", 16'({alu_cmd, alu_ina, alu_inb, alu_sc_i}), 16'h0);
    chk("rst_wb", 16'({wb_rd, wb_data}), 16'h0);
    check_regs_zero("rst_reg");
    rst_n = 1'b1;
    @(negedge clk);

    // ADD immediate and 0xFF+0x01 style wrap
    issue(3'b111, 3'd1, 3'd0, 1'b1, 8'h05);
    issue(3'b111, 3'd1, 3'd0, 1'b1, 8'hFB);
    // Logic ops with C=1 held
    issue(3'b011, 3'd3, 3'd0, 1'b1, 8'hA5);
    issue(3'b011, 3'd3, 3'd0, 1'b1, 8'hFF);
    issue(3'b101, 3'd3, 3'd0, 1'b1, 8'h0F);
    issue(3'b100, 3'd3, 3'd0, 1'b1, 8'h0B);
    issue(3'b011, 3'd6, 3'd0, 1'b1, 8'h07);
    // Carry chain
    issue(3'b111, 3'd2, 3'd0, 1'b1, 8'h0F);
    issue(3'b111, 3'd5, 3'd0, 1'b1, 8'hFF);
    issue(3'b111, 3'd5, 3'd0, 1'b1, 8'h01);
    issue(3'b111, 3'd2, 3'd0, 1'b1, 8'h01);
    // Register operands, including rd==rs
    issue(3'b111, 3'd2, 3'd2, 1'b0, 8'hEE);
    issue(3'b111, 3'd6, 3'd3, 1'b0, 8'h00);
    // Zero test taken, then not taken while the decoder holds the next instruction
    issue(3'b010, 3'd4, 3'd0, 1'b1, 8'h00);
    hold_next = 1'b1;
    nxt_op    = 3'b110;
    nxt_rd    = 3'd1;
    issue(3'b010, 3'd3, 3'd0, 1'b1, 8'h00);
    hold_next = 1'b0;
    issue(3'b110, 3'd1, 3'd2, 1'b0, 8'h00);
    issue(3'b000, 3'd2, 3'd2, 1'b1, 8'h44);

    // Reset in EXEC of an ADD aborts it
    wait_ready();
    instr_valid  = 1'b1;
    instr_op     = 3'b111;
    instr_rd     = 3'd1;
    instr_rs     = 3'd0;
    instr_imm_en = 1'b1;
    instr_imm    = 8'h33;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_exec", 16'(alu_cmd), 16'h7);
    rst_n = 1'b0;
    #1;
    chk("abort_alu_cleared", 16'(alu_cmd), 16'h0);
    chk("abort_ready", 16'(instr_ready), 16'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) ref_reg[i] = 8'h00;
    ref_c = 1'b0; ref_z = 1'b0; ref_p = 1'b0;
    @(negedge clk);
    chk("abort_no_wb_a", 16'(wb_valid), 16'h0);
    @(negedge clk);
    chk("abort_no_wb_b", 16'(wb_valid), 16'h0);
    chk("abort_flags", 16'({flag_c, flag_z, flag_p}), 16'h0);
    chk("abort_idle", 16'(instr_ready), 16'h1);
    check_regs_zero("abort_reg");

    // Normal operation resumes after reset
    issue(3'b111, 3'd7, 3'd0, 1'b1, 8'h80);

    chk("scoreboard_empty", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
